// File: rtl/conv_layer_sequencer_pkg.sv
// Shared definitions for the convolution layer sequencer.
//   - default parameter values for the table geometry and watchdog width
//   - seq_state_e: 3-bit FSM encoding, also exported on the dbg_state port
package conv_layer_sequencer_pkg;

  localparam int NUM_LAYERS_DEF = 4;
  localparam int LAYER_W_DEF    = 2;
  localparam int WGT_ADDR_W_DEF = 16;
  localparam int WGT_LEN_W_DEF  = 12;
  localparam int TIMEOUT_W_DEF  = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_REQ  = 3'd1,
    S_CONV_GO   = 3'd2,
    S_CONV_WAIT = 3'd3,
    S_SWAP      = 3'd4,
    S_FIN       = 3'd5,
    S_ERR       = 3'd6
  } seq_state_e;

endpackage

// File: rtl/conv_layer_sequencer_cfg_table.sv
// Per-layer descriptor register file: NUM_LAYERS entries of {weight base, weight length}.
// Ports:
//   clk1, rst_n          clock, async active-low reset (clears every entry)
//   i_we, i_busy         write strobe; a write is dropped while i_busy is high
//   i_wr_idx             slot written
//   i_wgt_base/i_wgt_len write data
//   i_rd_idx             slot read (asynchronous read)
//   o_rd_base/o_rd_len   read data
module conv_layer_sequencer_cfg_table #(
  parameter int NUM_LAYERS = 4,
  parameter int LAYER_W    = 2,
  parameter int WGT_ADDR_W = 16,
  parameter int WGT_LEN_W  = 12
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic                  i_busy,
  input  logic [LAYER_W-1:0]    i_wr_idx,
  input  logic [WGT_ADDR_W-1:0] i_wgt_base,
  input  logic [WGT_LEN_W-1:0]  i_wgt_len,
  input  logic [LAYER_W-1:0]    i_rd_idx,
  output logic [WGT_ADDR_W-1:0] o_rd_base,
  output logic [WGT_LEN_W-1:0]  o_rd_len
);

  logic [WGT_ADDR_W-1:0] r_base [NUM_LAYERS];
  logic [WGT_LEN_W-1:0]  r_len  [NUM_LAYERS];

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_base[i] <= '0;
        r_len[i]  <= '0;
      end
    end else if (i_we && !i_busy) begin
      r_base[i_wr_idx] <= i_wgt_base;
      r_len[i_wr_idx]  <= i_wgt_len;
    end
  end

  assign o_rd_base = r_base[i_rd_idx];
  assign o_rd_len  = r_len[i_rd_idx];

endmodule

// File: rtl/conv_layer_sequencer.sv
// Convolution layer sequencer: walks the descriptor table one layer at a time.
// Per layer: hold wgt_req until wgt_ack, pulse start_conv, wait for a rising edge of
// end_conv (guarded by a watchdog), then flip buf_sel. done pulses after the last layer.
// Ports:
//   clk1, rst_n                        clock, async active-low reset
//   start, cfg_nlayers                 run request and layer count (captured on start)
//   cfg_we/cfg_idx/cfg_wgt_base/len    descriptor writes, dropped while busy
//   wgt_req/wgt_addr/wgt_len, wgt_ack  weight loader handshake
//   start_conv, end_conv               conv controller handshake
//   buf_sel, layer_idx                 ping-pong select and current layer
//   busy, done, err                    status (err is sticky until the next accepted start)
//   dbg_state                          current FSM state
// Handshake: wgt_req rises and stays high until wgt_ack is seen in LOAD_REQ (an ack in
// the very first request cycle counts); acks in any other state are ignored. start_conv
// is a single-cycle pulse; only a 0->1 transition of end_conv completes a layer.
module conv_layer_sequencer
  import conv_layer_sequencer_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int LAYER_W    = LAYER_W_DEF,
  parameter int WGT_ADDR_W = WGT_ADDR_W_DEF,
  parameter int WGT_LEN_W  = WGT_LEN_W_DEF,
  parameter int TIMEOUT_W  = TIMEOUT_W_DEF
) (
  input  logic                  clk1,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  cfg_we,
  input  logic [LAYER_W-1:0]    cfg_idx,
  input  logic [WGT_ADDR_W-1:0] cfg_wgt_base,
  input  logic [WGT_LEN_W-1:0]  cfg_wgt_len,
  input  logic [LAYER_W:0]      cfg_nlayers,
  output logic                  wgt_req,
  output logic [WGT_ADDR_W-1:0] wgt_addr,
  output logic [WGT_LEN_W-1:0]  wgt_len,
  input  logic                  wgt_ack,
  output logic                  start_conv,
  input  logic                  end_conv,
  output logic                  buf_sel,
  output logic [LAYER_W-1:0]    layer_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output seq_state_e            dbg_state
);

  localparam logic [LAYER_W:0]     MAX_LAYERS = (LAYER_W+1)'(NUM_LAYERS);
  // Leaving CONV_WAIT on this count means the counter reaches all-ones on that edge.
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST  = {TIMEOUT_W{1'b1}} - 1'b1;

  seq_state_e             r_state;
  logic                   r_wgt_req;
  logic                   r_start_conv;
  logic                   r_buf_sel;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;
  logic                   r_end_q;
  logic [LAYER_W-1:0]     r_layer_idx;
  logic [LAYER_W:0]       r_nlayers;
  logic [TIMEOUT_W-1:0]   r_wdog;

  logic                   w_end_rise;
  logic                   w_last_layer;
  logic [LAYER_W:0]       w_nlayers_clamped;
  logic [WGT_ADDR_W-1:0]  w_tbl_base;
  logic [WGT_LEN_W-1:0]   w_tbl_len;

  conv_layer_sequencer_cfg_table #(
    .NUM_LAYERS (NUM_LAYERS),
    .LAYER_W    (LAYER_W),
    .WGT_ADDR_W (WGT_ADDR_W),
    .WGT_LEN_W  (WGT_LEN_W)
  ) u_cfg_table (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .i_we       (cfg_we),
    .i_busy     (r_busy),
    .i_wr_idx   (cfg_idx),
    .i_wgt_base (cfg_wgt_base),
    .i_wgt_len  (cfg_wgt_len),
    .i_rd_idx   (r_layer_idx),
    .o_rd_base  (w_tbl_base),
    .o_rd_len   (w_tbl_len)
  );

  assign w_end_rise        = end_conv & ~r_end_q;
  assign w_nlayers_clamped = (cfg_nlayers > MAX_LAYERS) ? MAX_LAYERS : cfg_nlayers;
  assign w_last_layer      = (({1'b0, r_layer_idx} + 1'b1) == r_nlayers);

  // end_q follows end_conv in every state so a level left high from the previous
  // layer can never look like a fresh completion.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) r_end_q <= 1'b0;
    else        r_end_q <= end_conv;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wgt_req    <= 1'b0;
      r_start_conv <= 1'b0;
      r_buf_sel    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_layer_idx  <= '0;
      r_nlayers    <= '0;
      r_wdog       <= '0;
    end else begin
      r_start_conv <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        S_IDLE, S_ERR: begin
          if (start) begin
            r_err       <= 1'b0;
            r_layer_idx <= '0;
            r_buf_sel   <= 1'b0;
            r_nlayers   <= w_nlayers_clamped;
            r_busy      <= 1'b1;
            if (w_nlayers_clamped == '0) begin
              r_state <= S_FIN;
            end else begin
              r_wgt_req <= 1'b1;
              r_state   <= S_LOAD_REQ;
            end
          end
        end
        S_LOAD_REQ: begin
          if (wgt_ack) begin
            r_wgt_req    <= 1'b0;
            r_start_conv <= 1'b1;
            r_state      <= S_CONV_GO;
          end
        end
        S_CONV_GO: begin
          r_wdog  <= '0;
          r_state <= S_CONV_WAIT;
        end
        S_CONV_WAIT: begin
          if (w_end_rise) begin
            r_state <= S_SWAP;
          end else begin
            r_wdog <= r_wdog + 1'b1;
            if (r_wdog == WDOG_LAST) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_ERR;
            end
          end
        end
        S_SWAP: begin
          r_buf_sel <= ~r_buf_sel;
          if (w_last_layer) begin
            r_state <= S_FIN;
          end else begin
            r_layer_idx <= r_layer_idx + 1'b1;
            r_wgt_req   <= 1'b1;
            r_state     <= S_LOAD_REQ;
          end
        end
        S_FIN: begin
          // done is raised on the way out of FIN so the FIN cycle itself is still busy.
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_wgt_req <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign wgt_req    = r_wgt_req;
  assign wgt_addr   = r_wgt_req ? w_tbl_base : '0;
  assign wgt_len    = r_wgt_req ? w_tbl_len  : '0;
  assign start_conv = r_start_conv;
  assign buf_sel    = r_buf_sel;
  assign layer_idx  = r_layer_idx;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer. Main instance uses default parameters;
// a second instance with a 4-bit watchdog exercises the timeout path.
module tb_conv_layer_sequencer;
  import conv_layer_sequencer_pkg::*;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_idx = '0;
  logic [15:0] cfg_wgt_base = '0;
  logic [11:0] cfg_wgt_len = '0;
  logic [2:0]  cfg_nlayers = '0;
  logic        wgt_ack = 1'b0;
  logic        end_conv = 1'b0;

  logic        wgt_req, start_conv, buf_sel, busy, done, err;
  logic [15:0] wgt_addr;
  logic [11:0] wgt_len;
  logic [1:0]  layer_idx;
  seq_state_e  dbg_state;

  logic        wd_wgt_req, wd_start_conv, wd_buf_sel, wd_busy, wd_done, wd_err;
  logic [15:0] wd_wgt_addr;
  logic [11:0] wd_wgt_len;
  logic [1:0]  wd_layer_idx;
  seq_state_e  wd_dbg_state;

  int n_pass = 0;
  int n_total = 0;
  int n_sc = 0;
  int n_req = 0;
  int n_done = 0;

  // ---------------- clock / reset ----------------
  always #5 clk1 = ~clk1;

  conv_layer_sequencer dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_wgt_base(cfg_wgt_base), .cfg_wgt_len(cfg_wgt_len), .cfg_nlayers(cfg_nlayers),
    .wgt_req(wgt_req), .wgt_addr(wgt_addr), .wgt_len(wgt_len), .wgt_ack(wgt_ack),
    .start_conv(start_conv), .end_conv(end_conv), .buf_sel(buf_sel), .layer_idx(layer_idx),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  conv_layer_sequencer #(.TIMEOUT_W(4)) dut_wd (
    .clk1(clk1), .rst_n(rst_n), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_wgt_base(cfg_wgt_base), .cfg_wgt_len(cfg_wgt_len), .cfg_nlayers(cfg_nlayers),
    .wgt_req(wd_wgt_req), .wgt_addr(wd_wgt_addr), .wgt_len(wd_wgt_len), .wgt_ack(wgt_ack),
    .start_conv(wd_start_conv), .end_conv(end_conv), .buf_sel(wd_buf_sel),
    .layer_idx(wd_layer_idx), .busy(wd_busy), .done(wd_done), .err(wd_err),
    .dbg_state(wd_dbg_state)
  );

  // Event monitors for the main instance, sampled mid-cycle.
  always @(negedge clk1) begin
    if (start_conv) n_sc++;
    if (wgt_req)    n_req++;
    if (done)       n_done++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; cfg_we = 1'b0; wgt_ack = 1'b0; end_conv = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic write_cfg(input logic [1:0] idx, input logic [15:0] base, input logic [11:0] len);
    cfg_we = 1'b1; cfg_idx = idx; cfg_wgt_base = base; cfg_wgt_len = len;
    tick();
    cfg_we = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_total++;
    if ({wgt_req, start_conv, buf_sel, busy, done, err, wgt_addr, wgt_len, layer_idx} !== '0)
      $display("FAIL reset_outputs: got %h want 0",
               {wgt_req, start_conv, buf_sel, busy, done, err, wgt_addr, wgt_len, layer_idx});
    else n_pass++;
    n_total++;
    if (dbg_state !== S_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE);
    else n_pass++;
    n_total++;
    if ({wd_wgt_req, wd_start_conv, wd_buf_sel, wd_busy, wd_done, wd_err, wd_wgt_addr,
         wd_wgt_len, wd_layer_idx, wd_dbg_state} !== '0)
      $display("FAIL reset_wd_outputs: got %h want 0",
               {wd_wgt_req, wd_start_conv, wd_buf_sel, wd_busy, wd_done, wd_err, wd_wgt_addr,
                wd_wgt_len, wd_layer_idx, wd_dbg_state});
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_three_layers();
    logic [15:0] bases [3];
    int sc0, d0;
    logic exp_b;
    bases = '{16'h100, 16'h200, 16'h300};
    for (int i = 0; i < 3; i++) write_cfg(2'(i), bases[i], 12'd16);
    sc0 = n_sc; d0 = n_done;
    cfg_nlayers = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int l = 0; l < 3; l++) begin
      exp_b = l[0];
      n_total++;
      if (wgt_req !== 1'b1) $display("FAIL t1_req L%0d: got %b want 1", l, wgt_req); else n_pass++;
      n_total++;
      if (wgt_addr !== bases[l]) $display("FAIL t1_addr L%0d: got %h want %h", l, wgt_addr, bases[l]); else n_pass++;
      n_total++;
      if (wgt_len !== 12'd16) $display("FAIL t1_len L%0d: got %0d want 16", l, wgt_len); else n_pass++;
      n_total++;
      if (layer_idx !== 2'(l)) $display("FAIL t1_layer L%0d: got %0d want %0d", l, layer_idx, l); else n_pass++;
      n_total++;
      if (buf_sel !== exp_b) $display("FAIL t1_bufsel_pre L%0d: got %b want %b", l, buf_sel, exp_b); else n_pass++;
      repeat (4) tick();
      wgt_ack = 1'b1;
      tick();
      wgt_ack = 1'b0;
      n_total++;
      if (start_conv !== 1'b1 || wgt_req !== 1'b0)
        $display("FAIL t1_startconv L%0d: got sc=%b req=%b want sc=1 req=0", l, start_conv, wgt_req);
      else n_pass++;
      tick();
      n_total++;
      if (start_conv !== 1'b0) $display("FAIL t1_sc_pulse L%0d: got %b want 0", l, start_conv); else n_pass++;
      repeat (38) tick();
      end_conv = 1'b1;
      tick();
      end_conv = 1'b0;
      n_total++;
      if (dbg_state !== S_SWAP) $display("FAIL t1_swap L%0d: got %0d want %0d", l, dbg_state, S_SWAP); else n_pass++;
      tick();
      n_total++;
      if (buf_sel !== ~exp_b) $display("FAIL t1_bufsel_post L%0d: got %b want %b", l, buf_sel, ~exp_b); else n_pass++;
    end
    n_total++;
    if (done !== 1'b0 || busy !== 1'b1) $display("FAIL t1_fin: got done=%b busy=%b want 0/1", done, busy); else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL t1_done: got done=%b busy=%b want 1/0", done, busy); else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b0) $display("FAIL t1_done_pulse: got %b want 0", done); else n_pass++;
    n_total++;
    if (n_sc - sc0 != 3) $display("FAIL t1_sc_count: got %0d want 3", n_sc - sc0); else n_pass++;
    n_total++;
    if (n_done - d0 != 1) $display("FAIL t1_done_count: got %0d want 1", n_done - d0); else n_pass++;
  endtask

  task automatic test_zero_layers();
    int rq0, sc0, d0;
    rq0 = n_req; sc0 = n_sc; d0 = n_done;
    cfg_nlayers = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1 || done !== 1'b0 || dbg_state !== S_FIN)
      $display("FAIL t2_fin: got busy=%b done=%b st=%0d want 1/0/%0d", busy, done, dbg_state, S_FIN);
    else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL t2_done: got done=%b busy=%b want 1/0", done, busy); else n_pass++;
    tick();
    n_total++;
    if (n_req != rq0 || n_sc != sc0 || n_done != d0 + 1)
      $display("FAIL t2_counts: got req=%0d sc=%0d done=%0d want 0/0/1", n_req - rq0, n_sc - sc0, n_done - d0);
    else n_pass++;
  endtask

  task automatic test_end_level_held();
    cfg_nlayers = 3'd2; start = 1'b1; wgt_ack = 1'b1;   // ack while IDLE must be ignored
    tick();
    start = 1'b0;
    n_total++;
    if (wgt_req !== 1'b1 || start_conv !== 1'b0)
      $display("FAIL t3_idle_ack: got req=%b sc=%b want 1/0", wgt_req, start_conv);
    else n_pass++;
    tick();                                             // ack in first request cycle
    wgt_ack = 1'b0;
    n_total++;
    if (start_conv !== 1'b1) $display("FAIL t3_first_ack: got %b want 1", start_conv); else n_pass++;
    repeat (4) tick();
    end_conv = 1'b1;
    tick();                                             // layer 0 -> SWAP
    tick();                                             // LOAD_REQ layer 1
    n_total++;
    if (layer_idx !== 2'd1 || wgt_req !== 1'b1 || wgt_addr !== 16'h200 || buf_sel !== 1'b1)
      $display("FAIL t3_layer1: got idx=%0d req=%b addr=%h buf=%b want 1/1/200/1", layer_idx, wgt_req, wgt_addr, buf_sel);
    else n_pass++;
    wgt_ack = 1'b1;
    tick();
    wgt_ack = 1'b0;
    tick();
    repeat (6) tick();                                  // end_conv high for 10 edges in total
    n_total++;
    if (dbg_state !== S_CONV_WAIT || layer_idx !== 2'd1)
      $display("FAIL t3_held_level: got st=%0d idx=%0d want %0d/1", dbg_state, layer_idx, S_CONV_WAIT);
    else n_pass++;
    end_conv = 1'b0;
    repeat (2) tick();
    n_total++;
    if (dbg_state !== S_CONV_WAIT) $display("FAIL t3_low: got st=%0d want %0d", dbg_state, S_CONV_WAIT); else n_pass++;
    end_conv = 1'b1;
    tick();
    end_conv = 1'b0;
    n_total++;
    if (dbg_state !== S_SWAP) $display("FAIL t3_rise: got st=%0d want %0d", dbg_state, S_SWAP); else n_pass++;
    tick();
    n_total++;
    if (buf_sel !== 1'b0 || dbg_state !== S_FIN)
      $display("FAIL t3_fin: got buf=%b st=%0d want 0/%0d", buf_sel, dbg_state, S_FIN);
    else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b1) $display("FAIL t3_done: got %b want 1", done); else n_pass++;
  endtask

  task automatic test_watchdog();
    do_reset();
    write_cfg(2'd0, 16'h0AB, 12'd5);
    cfg_nlayers = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if (wd_wgt_req !== 1'b1) $display("FAIL t4_req: got %b want 1", wd_wgt_req); else n_pass++;
    wgt_ack = 1'b1;
    tick();
    wgt_ack = 1'b0;
    n_total++;
    if (wd_start_conv !== 1'b1) $display("FAIL t4_sc: got %b want 1", wd_start_conv); else n_pass++;
    repeat (15) tick();
    n_total++;
    if (wd_err !== 1'b0 || wd_busy !== 1'b1)
      $display("FAIL t4_pre_timeout: got err=%b busy=%b want 0/1", wd_err, wd_busy);
    else n_pass++;
    tick();
    n_total++;
    if (wd_err !== 1'b1 || wd_busy !== 1'b0 || wd_dbg_state !== S_ERR)
      $display("FAIL t4_timeout: got err=%b busy=%b st=%0d want 1/0/%0d", wd_err, wd_busy, wd_dbg_state, S_ERR);
    else n_pass++;
    tick();
    n_total++;
    if (wd_err !== 1'b1) $display("FAIL t4_sticky: got %b want 1", wd_err); else n_pass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if (wd_err !== 1'b0 || wd_wgt_req !== 1'b1 || wd_layer_idx !== 2'd0 || wd_buf_sel !== 1'b0 || wd_wgt_addr !== 16'h0AB)
      $display("FAIL t4_restart: got err=%b req=%b idx=%0d buf=%b addr=%h want 0/1/0/0/0ab",
               wd_err, wd_wgt_req, wd_layer_idx, wd_buf_sel, wd_wgt_addr);
    else n_pass++;
  endtask

  task automatic test_busy_ignores();
    int sc0;
    do_reset();
    write_cfg(2'd0, 16'h100, 12'd16);
    write_cfg(2'd1, 16'h200, 12'd16);
    // Write to slot 1 coincident with start must land.
    cfg_nlayers = 3'd2; start = 1'b1;
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_wgt_base = 16'h250; cfg_wgt_len = 12'd8;
    tick();
    // Start and write while busy must be dropped.
    cfg_idx = 2'd0; cfg_wgt_base = 16'hDEAD; cfg_wgt_len = 12'h7FF;
    tick();
    start = 1'b0; cfg_we = 1'b0;
    n_total++;
    if (busy !== 1'b1 || wgt_req !== 1'b1 || layer_idx !== 2'd0 || wgt_addr !== 16'h100 || wgt_len !== 12'd16)
      $display("FAIL t5_busy_write: got busy=%b req=%b idx=%0d addr=%h len=%0d want 1/1/0/100/16",
               busy, wgt_req, layer_idx, wgt_addr, wgt_len);
    else n_pass++;
    wgt_ack = 1'b1;
    tick();
    wgt_ack = 1'b0;
    tick();
    sc0 = n_sc;
    wgt_ack = 1'b1; start = 1'b1;                       // both must be ignored in CONV_WAIT
    tick();
    wgt_ack = 1'b0; start = 1'b0;
    tick();
    n_total++;
    if (dbg_state !== S_CONV_WAIT || busy !== 1'b1 || n_sc != sc0)
      $display("FAIL t5_wait_ignores: got st=%0d busy=%b sc=%0d want %0d/1/0", dbg_state, busy, n_sc - sc0, S_CONV_WAIT);
    else n_pass++;
    end_conv = 1'b1;
    tick();
    end_conv = 1'b0;
    tick();
    n_total++;
    if (wgt_addr !== 16'h250 || wgt_len !== 12'd8)
      $display("FAIL t5_start_cycle_write: got addr=%h len=%0d want 250/8", wgt_addr, wgt_len);
    else n_pass++;
    wgt_ack = 1'b1;
    tick();
    wgt_ack = 1'b0;
    tick();
    end_conv = 1'b1;
    tick();
    end_conv = 1'b0;
    tick();                                             // FIN
    start = 1'b1;                                       // start during FIN is ignored
    tick();
    start = 1'b0;
    n_total++;
    if (done !== 1'b1 || busy !== 1'b0) $display("FAIL t5_fin_start: got done=%b busy=%b want 1/0", done, busy); else n_pass++;
    tick();
    n_total++;
    if (busy !== 1'b0 || wgt_req !== 1'b0 || dbg_state !== S_IDLE)
      $display("FAIL t5_idle: got busy=%b req=%b st=%0d want 0/0/%0d", busy, wgt_req, dbg_state, S_IDLE);
    else n_pass++;
    cfg_nlayers = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if (wgt_addr !== 16'h100 || wgt_len !== 12'd16)
      $display("FAIL t5_table_kept: got addr=%h len=%0d want 100/16", wgt_addr, wgt_len);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    write_cfg(2'd0, 16'h100, 12'd16);
    write_cfg(2'd1, 16'h200, 12'd16);
    cfg_nlayers = 3'd2; start = 1'b1;
    tick();
    start = 1'b0; wgt_ack = 1'b1;
    tick();
    wgt_ack = 1'b0;
    tick();
    end_conv = 1'b1;
    tick();
    end_conv = 1'b0;
    tick();
    wgt_ack = 1'b1;
    tick();
    wgt_ack = 1'b0;
    repeat (2) tick();
    n_total++;
    if (dbg_state !== S_CONV_WAIT || layer_idx !== 2'd1 || buf_sel !== 1'b1)
      $display("FAIL t6_setup: got st=%0d idx=%0d buf=%b want %0d/1/1", dbg_state, layer_idx, buf_sel, S_CONV_WAIT);
    else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if ({wgt_req, start_conv, buf_sel, busy, done, err, wgt_addr, wgt_len, layer_idx} !== '0 || dbg_state !== S_IDLE)
      $display("FAIL t6_async_reset: got %h st=%0d want 0/%0d",
               {wgt_req, start_conv, buf_sel, busy, done, err, wgt_addr, wgt_len, layer_idx}, dbg_state, S_IDLE);
    else n_pass++;
    tick();
    n_total++;
    if (done !== 1'b0 || err !== 1'b0) $display("FAIL t6_no_done_err: got done=%b err=%b want 0/0", done, err); else n_pass++;
    rst_n = 1'b1;
    tick();
    write_cfg(2'd0, 16'h0C0, 12'd16);
    cfg_nlayers = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    n_total++;
    if (layer_idx !== 2'd0 || buf_sel !== 1'b0 || wgt_req !== 1'b1 || wgt_addr !== 16'h0C0)
      $display("FAIL t6_fresh_run: got idx=%0d buf=%b req=%b addr=%h want 0/0/1/0c0", layer_idx, buf_sel, wgt_req, wgt_addr);
    else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_three_layers();
    test_zero_layers();
    test_end_level_held();
    test_watchdog();
    test_busy_ignores();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
